// File: rtl/axi4_lsu_master64.sv
// axi4_lsu_master64: single-outstanding load/store bridge onto a 64-bit AXI4 master port
module axi4_lsu_master64 #(
  parameter logic [3:0] AXI_ID = 4'd0,
  parameter int         ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              out_arvalid,
  input  logic              out_arready,
  output logic [3:0]        out_arid,
  output logic [ADDR_W-1:0] out_araddr,
  output logic [7:0]        out_arlen,
  output logic [2:0]        out_arsize,
  output logic [1:0]        out_arburst,
  output logic              out_rready,
  input  logic              out_rvalid,
  input  logic [3:0]        out_rid,
  input  logic [63:0]       out_rdata,
  input  logic [1:0]        out_rresp,
  input  logic              out_rlast,
  output logic              out_awvalid,
  input  logic              out_awready,
  output logic [3:0]        out_awid,
  output logic [ADDR_W-1:0] out_awaddr,
  output logic [7:0]        out_awlen,
  output logic [2:0]        out_awsize,
  output logic [1:0]        out_awburst,
  output logic              out_wvalid,
  input  logic              out_wready,
  output logic [63:0]       out_wdata,
  output logic [7:0]        out_wstrb,
  output logic              out_wlast,
  output logic              out_bready,
  input  logic              out_bvalid,
  input  logic [3:0]        out_bid,
  input  logic [1:0]        out_bresp
);
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_RESP} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              wen_q, wen_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic              mis_q, mis_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [2:0]        low_mask;
  logic              mis;
  logic [2:0]        off;
  logic [63:0]       byte_mask;
  logic [7:0]        strb_base;
  logic              unused_in;
  assign unused_in = ^{out_rid, out_bid, out_rlast, wen_q};
  assign off = addr_q[2:0];
  assign low_mask = req_size == 2'd3 ? 3'b111 : req_size == 2'd2 ? 3'b011 : req_size == 2'd1 ? 3'b001 : 3'b000;
  assign mis = |(req_addr[2:0] & low_mask);
  assign byte_mask = size_q == 2'd3 ? 64'hFFFF_FFFF_FFFF_FFFF : size_q == 2'd2 ? 64'hFFFF_FFFF :
                     size_q == 2'd1 ? 64'hFFFF : 64'hFF;
  assign strb_base = size_q == 2'd3 ? 8'hFF : size_q == 2'd2 ? 8'h0F : size_q == 2'd1 ? 8'h03 : 8'h01;
  assign req_ready   = state_q == S_IDLE;
  assign resp_valid  = state_q == S_RESP;
  assign resp_err    = (state_q == S_RESP) & (mis_q | (|resp_q));
  assign resp_rdata  = rdata_q;
  assign out_arvalid = state_q == S_AR;
  assign out_arid    = AXI_ID;
  assign out_araddr  = addr_q;
  assign out_arlen   = 8'd0;
  assign out_arsize  = {1'b0, size_q};
  assign out_arburst = 2'b01;
  assign out_rready  = state_q == S_R;
  assign out_awvalid = (state_q == S_WR) & ~aw_done_q;
  assign out_awid    = AXI_ID;
  assign out_awaddr  = addr_q;
  assign out_awlen   = 8'd0;
  assign out_awsize  = {1'b0, size_q};
  assign out_awburst = 2'b01;
  assign out_wvalid  = (state_q == S_WR) & ~w_done_q;
  assign out_wdata   = wdata_q << {off, 3'b000};
  assign out_wstrb   = strb_base << off;
  assign out_wlast   = 1'b1;
  assign out_bready  = state_q == S_B;
  // next-state and transaction capture
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    mis_d     = mis_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        addr_d    = req_addr;
        size_d    = req_size;
        wen_d     = req_wen;
        wdata_d   = req_wdata;
        rdata_d   = '0;
        resp_d    = 2'b00;
        mis_d     = mis;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        state_d   = mis ? S_RESP : req_wen ? S_WR : S_AR;
      end
      S_AR: state_d = out_arready ? S_R : S_AR;
      S_R: if (out_rvalid) begin
        rdata_d = (out_rdata >> {off, 3'b000}) & byte_mask;
        resp_d  = out_rresp;
        state_d = S_RESP;
      end
      S_WR: begin
        aw_done_d = aw_done_q | out_awready;
        w_done_d  = w_done_q | out_wready;
        state_d   = (aw_done_d & w_done_d) ? S_B : S_WR;
      end
      S_B: if (out_bvalid) begin
        resp_d  = out_bresp;
        state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state and transaction registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      mis_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      mis_q     <= mis_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axi4_lsu_master64.sv
// tb_axi4_lsu_master64: directed vector bench with a negedge AXI slave model
module tb_axi4_lsu_master64;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0] req_size = '0;
  logic [63:0] req_wdata = '0;
  logic resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic out_arvalid, out_arready;
  logic [3:0] out_arid, out_awid, out_rid, out_bid;
  logic [31:0] out_araddr, out_awaddr;
  logic [7:0] out_arlen, out_awlen, out_wstrb;
  logic [2:0] out_arsize, out_awsize;
  logic [1:0] out_arburst, out_awburst, out_rresp, out_bresp;
  logic out_rready, out_rvalid, out_rlast;
  logic [63:0] out_rdata, out_wdata;
  logic out_awvalid, out_awready, out_wvalid, out_wready, out_wlast;
  logic out_bready, out_bvalid;

  axi4_lsu_master64 dut (
    .clock(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .out_arvalid(out_arvalid), .out_arready(out_arready), .out_arid(out_arid), .out_araddr(out_araddr),
    .out_arlen(out_arlen), .out_arsize(out_arsize), .out_arburst(out_arburst),
    .out_rready(out_rready), .out_rvalid(out_rvalid), .out_rid(out_rid), .out_rdata(out_rdata),
    .out_rresp(out_rresp), .out_rlast(out_rlast),
    .out_awvalid(out_awvalid), .out_awready(out_awready), .out_awid(out_awid), .out_awaddr(out_awaddr),
    .out_awlen(out_awlen), .out_awsize(out_awsize), .out_awburst(out_awburst),
    .out_wvalid(out_wvalid), .out_wready(out_wready), .out_wdata(out_wdata), .out_wstrb(out_wstrb),
    .out_wlast(out_wlast),
    .out_bready(out_bready), .out_bvalid(out_bvalid), .out_bid(out_bid), .out_bresp(out_bresp)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int ar_delay = 0, aw_delay = 0, w_delay = 0, ar_wait = 0, aw_wait = 0, w_wait = 0;
  logic r_hold = 1'b0;
  logic [63:0] slv_rdata = '0;
  logic [1:0] slv_rresp = '0, slv_bresp = '0;
  int cyc = 0, acc_cnt = 0, acc_cyc = 0, resp_cnt = 0, resp_cyc = 0;
  int ar_hs = 0, aw_hs = 0, w_hs = 0, ar_unstable = 0, b2b_bad = 0;
  logic ar_seen = 1'b0, prev_resp = 1'b0;
  logic [31:0] ar_first, cap_araddr;
  logic [2:0] ar_size_first, cap_arsize;
  logic [63:0] cap_wdata, cap_rdata;
  logic [7:0] cap_wstrb;
  logic cap_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // slave model and monitor: decides readies for the coming edge and records handshakes
  initial begin
    out_arready = 0; out_rvalid = 0; out_rid = 4'h5; out_rdata = '0; out_rresp = '0; out_rlast = 1;
    out_awready = 0; out_wready = 0; out_bvalid = 0; out_bid = 4'h3; out_bresp = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (resp_valid) begin resp_cnt++; resp_cyc = cyc; cap_rdata = resp_rdata; cap_err = resp_err; end
      if (prev_resp && !req_ready) b2b_bad++;
      prev_resp = resp_valid;
      if (rst) begin
        out_arready = 0; out_rvalid = 0; out_awready = 0; out_wready = 0; out_bvalid = 0;
        ar_seen = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
        continue;
      end
      if (req_valid && req_ready) begin acc_cnt++; acc_cyc = cyc; end
      if (out_arvalid) begin
        if (ar_seen && (out_araddr !== ar_first || out_arsize !== ar_size_first)) ar_unstable++;
        if (!ar_seen) begin ar_seen = 1; ar_first = out_araddr; ar_size_first = out_arsize; end
        out_arready = ar_wait >= ar_delay;
        ar_wait++;
        if (out_arready) begin ar_hs++; cap_araddr = out_araddr; cap_arsize = out_arsize; ar_seen = 0; ar_wait = 0; end
      end else out_arready = 0;
      out_rvalid = out_rready && !r_hold;
      out_rdata = slv_rdata;
      out_rresp = slv_rresp;
      if (out_awvalid) begin
        out_awready = aw_wait >= aw_delay;
        aw_wait++;
        if (out_awready) begin aw_hs++; aw_wait = 0; end
      end else out_awready = 0;
      if (out_wvalid) begin
        out_wready = w_wait >= w_delay;
        w_wait++;
        if (out_wready) begin w_hs++; w_wait = 0; cap_wdata = out_wdata; cap_wstrb = out_wstrb; end
      end else out_wready = 0;
      out_bvalid = out_bready;
      out_bresp = slv_bresp;
    end
  end

  typedef struct {
    logic wen; logic [31:0] addr; logic [1:0] size; logic [63:0] wdata; logic [63:0] sdata;
    logic [1:0] rresp; logic [1:0] bresp; int ard; int awd; int wd;
    logic [63:0] exp_rdata; logic exp_err; logic [7:0] exp_strb; logic [63:0] exp_wdata;
    int exp_ar; int exp_aw; int exp_lat;
  } vec_t;
  vec_t v[12];

  initial begin
    int s_ar, s_aw, s_w, s_resp, s_acc, s_unst, k;
    v[0]  = '{0, 32'h8000_0004, 2'd2, 64'h0, 64'h1122_3344_5566_7788, 0, 0, 0, 0, 0,
              64'h1122_3344, 0, 8'h00, 64'h0, 1, 0, 3};
    v[1]  = '{1, 32'h8000_0000, 2'd2, 64'hDEAD_BEEF, 64'h0, 0, 0, 0, 0, 0,
              64'h0, 0, 8'h0F, 64'h0000_0000_DEAD_BEEF, 0, 1, 3};
    v[2]  = '{1, 32'h8000_0004, 2'd2, 64'hDEAD_BEEF, 64'h0, 0, 0, 0, 0, 0,
              64'h0, 0, 8'hF0, 64'hDEAD_BEEF_0000_0000, 0, 1, 3};
    v[3]  = '{1, 32'h8000_0007, 2'd0, 64'hAB, 64'h0, 0, 0, 0, 3, 0,
              64'h0, 0, 8'h80, 64'hAB00_0000_0000_0000, 0, 1, 0};
    v[4]  = '{0, 32'h8000_0006, 2'd1, 64'h0, 64'h1122_3344_5566_7788, 0, 0, 0, 0, 0,
              64'h1122, 0, 8'h00, 64'h0, 1, 0, 3};
    v[5]  = '{0, 32'h8000_0008, 2'd3, 64'h0, 64'h1122_3344_5566_7788, 0, 0, 0, 0, 0,
              64'h1122_3344_5566_7788, 0, 8'h00, 64'h0, 1, 0, 3};
    v[6]  = '{0, 32'h8000_0003, 2'd0, 64'h0, 64'h1122_3344_5566_7788, 0, 0, 0, 0, 0,
              64'h55, 0, 8'h00, 64'h0, 1, 0, 3};
    v[7]  = '{0, 32'h8000_0010, 2'd2, 64'h0, 64'h1122_3344_5566_7788, 2'b10, 0, 5, 0, 0,
              64'h5566_7788, 1, 8'h00, 64'h0, 1, 0, 8};
    v[8]  = '{1, 32'h8000_0002, 2'd1, 64'h1234, 64'h0, 0, 2'b11, 0, 0, 0,
              64'h0, 1, 8'h0C, 64'h0000_0000_1234_0000, 0, 1, 3};
    v[9]  = '{0, 32'h8000_0002, 2'd2, 64'h0, 64'h1122_3344_5566_7788, 0, 0, 0, 0, 0,
              64'h0, 1, 8'h00, 64'h0, 0, 0, 1};
    v[10] = '{1, 32'h8000_0004, 2'd3, 64'hFFFF, 64'h0, 0, 0, 0, 0, 0,
              64'h0, 1, 8'h00, 64'h0, 0, 0, 1};
    v[11] = '{1, 32'h8000_0018, 2'd3, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, 0, 0, 2,
              64'h0, 0, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 1, 5};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_valids", {out_arvalid, out_awvalid, out_wvalid, out_rready, out_bready, resp_valid, resp_err}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("consts", {out_arlen, out_awlen, out_arburst, out_awburst, out_wlast, out_arid, out_awid},
        {8'd0, 8'd0, 2'b01, 2'b01, 1'b1, 4'd0, 4'd0});
    for (int i = 0; i < 12; i++) begin
      ar_delay = v[i].ard; aw_delay = v[i].awd; w_delay = v[i].wd;
      slv_rdata = v[i].sdata; slv_rresp = v[i].rresp; slv_bresp = v[i].bresp;
      s_ar = ar_hs; s_aw = aw_hs; s_w = w_hs; s_resp = resp_cnt; s_acc = acc_cnt; s_unst = ar_unstable;
      @(posedge clk); #1;
      req_valid = 1; req_wen = v[i].wen; req_addr = v[i].addr; req_size = v[i].size; req_wdata = v[i].wdata;
      @(posedge clk); #1;
      req_valid = 0;
      chk($sformatf("v%0d_accept", i), 64'(acc_cnt - s_acc), 1);
      for (k = 0; k < 40 && resp_cnt == s_resp; k++) begin @(posedge clk); #1; end
      chk($sformatf("v%0d_resp_seen", i), 64'(resp_cnt != s_resp), 1);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d_one_pulse", i), 64'(resp_cnt - s_resp), 1);
      chk($sformatf("v%0d_err", i), cap_err, v[i].exp_err);
      chk($sformatf("v%0d_rdata", i), cap_rdata, v[i].exp_rdata);
      chk($sformatf("v%0d_ar_hs", i), 64'(ar_hs - s_ar), 64'(v[i].exp_ar));
      chk($sformatf("v%0d_aw_hs", i), 64'(aw_hs - s_aw), 64'(v[i].exp_aw));
      chk($sformatf("v%0d_w_hs", i), 64'(w_hs - s_w), 64'(v[i].exp_aw));
      if (v[i].exp_lat != 0) chk($sformatf("v%0d_latency", i), 64'(resp_cyc - acc_cyc), 64'(v[i].exp_lat));
      if (v[i].exp_ar != 0) begin
        chk($sformatf("v%0d_araddr", i), cap_araddr, v[i].addr);
        chk($sformatf("v%0d_arsize", i), cap_arsize, {1'b0, v[i].size});
        chk($sformatf("v%0d_ar_stable", i), 64'(ar_unstable - s_unst), 0);
      end
      if (v[i].exp_aw != 0) begin
        chk($sformatf("v%0d_wstrb", i), cap_wstrb, v[i].exp_strb);
        chk($sformatf("v%0d_wdata", i), cap_wdata, v[i].exp_wdata);
      end
    end
    chk("back_to_back_ready", 64'(b2b_bad), 0);
    // true back-to-back: second request presented in the cycle right after resp_valid
    ar_delay = 0; slv_rresp = 0; slv_rdata = 64'hCAFE_F00D_0BAD_BEEF;
    s_resp = resp_cnt; s_acc = acc_cnt;
    @(posedge clk); #1;
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0000; req_size = 2'd3;
    for (k = 0; k < 40 && acc_cnt - s_acc < 2; k++) begin @(posedge clk); #1; end
    req_valid = 0;
    chk("b2b_accepts", 64'(acc_cnt - s_acc), 2);
    repeat (6) @(posedge clk);
    #1;
    chk("b2b_resps", 64'(resp_cnt - s_resp), 2);
    chk("b2b_rdata", cap_rdata, 64'hCAFE_F00D_0BAD_BEEF);
    chk("b2b_ready_gap", 64'(b2b_bad), 0);
    // reset while waiting in R
    r_hold = 1; s_resp = resp_cnt;
    @(posedge clk); #1;
    req_valid = 1; req_wen = 0; req_addr = 32'h8000_0020; req_size = 2'd2;
    @(posedge clk); #1;
    req_valid = 0;
    for (k = 0; k < 20 && !out_rready; k++) begin @(posedge clk); #1; end
    chk("rst_mid_in_r", out_rready, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_valids", {out_arvalid, out_awvalid, out_wvalid, out_rready, out_bready, resp_valid}, 0);
    chk("rst_mid_ready", req_ready, 1);
    rst = 0; r_hold = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_mid_no_resp", 64'(resp_cnt - s_resp), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
